// File: rtl/serial_magnitude_comparator_if.sv
// Request/result bundle for the serial magnitude comparator.
// The master side issues operands and cascade bits; the slave side returns
// busy, a one-cycle done pulse and the one-hot LT/GT/EQ result.
interface serial_magnitude_comparator_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic             sgn;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             l;
    logic             e;
    logic             g;
    logic             busy;
    logic             done;
    logic             LT;
    logic             GT;
    logic             EQ;

    modport master (
        output start, sgn, a, b, l, e, g,
        input  busy, done, LT, GT, EQ
    );

    modport slave (
        input  start, sgn, a, b, l, e, g,
        output busy, done, LT, GT, EQ
    );
endinterface

// File: rtl/serial_magnitude_comparator.sv
// Bit-serial magnitude comparator. Operands are latched on start and scanned
// MSB-first, one bit per clock, stopping at the first differing bit. When all
// bits match, the latched cascade inputs from a less-significant stage decide
// the result. Every output is a flop; nothing on the bus reaches an output
// combinationally. WIDTH is meant to stay within 2..32.
module serial_magnitude_comparator #(
    parameter int WIDTH = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    serial_magnitude_comparator_if.slave  bus
);
    localparam int IW = $clog2(WIDTH);
    localparam logic [IW-1:0] MSB_IDX = IW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [IW-1:0]    idx;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             sgn_q;
    logic             l_q;
    logic             e_q;
    logic             g_q;
    logic             busy_q;
    logic             done_q;
    logic             lt_q;
    logic             gt_q;
    logic             eq_q;

    // e only matters as the fallback when neither l nor g is set, and EQ is
    // that fallback anyway, so the latched copy never steers the result.
    logic             e_unused;
    assign e_unused = e_q;

    logic bit_a;
    logic bit_b;
    logic at_msb;
    logic a_wins;

    // Decision for the bit under the scan pointer; the sign bit of a signed
    // compare flips the sense (a 1 there means a is negative, so smaller).
    always_comb begin
        bit_a  = a_q[idx];
        bit_b  = b_q[idx];
        at_msb = (idx == MSB_IDX);
        a_wins = bit_a ^ (sgn_q & at_msb);
    end

    // Control FSM with operand latch, scan pointer and registered results.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            idx    <= MSB_IDX;
            a_q    <= '0;
            b_q    <= '0;
            sgn_q  <= 1'b0;
            l_q    <= 1'b0;
            e_q    <= 1'b0;
            g_q    <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            lt_q   <= 1'b0;
            gt_q   <= 1'b0;
            eq_q   <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    // DONE accepts a new request too, giving back-to-back ops.
                    done_q <= 1'b0;
                    if (bus.start) begin
                        a_q    <= bus.a;
                        b_q    <= bus.b;
                        sgn_q  <= bus.sgn;
                        l_q    <= bus.l;
                        e_q    <= bus.e;
                        g_q    <= bus.g;
                        idx    <= MSB_IDX;
                        busy_q <= 1'b1;
                        state  <= SCAN;
                    end else begin
                        busy_q <= 1'b0;
                        state  <= IDLE;
                    end
                end

                SCAN: begin
                    // start is deliberately ignored here.
                    if (bit_a != bit_b) begin
                        lt_q   <= ~a_wins;
                        gt_q   <= a_wins;
                        eq_q   <= 1'b0;
                        done_q <= 1'b1;
                        busy_q <= 1'b0;
                        state  <= DONE;
                    end else if (idx != '0) begin
                        idx <= idx - IW'(1);
                    end else begin
                        // All bits equal: cascade decides, l beats g beats e.
                        lt_q   <= l_q;
                        gt_q   <= ~l_q & g_q;
                        eq_q   <= ~l_q & ~g_q;
                        done_q <= 1'b1;
                        busy_q <= 1'b0;
                        state  <= DONE;
                    end
                end

                default: begin
                    done_q <= 1'b0;
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.LT   = lt_q;
    assign bus.GT   = gt_q;
    assign bus.EQ   = eq_q;
endmodule

// File: tb/tb_serial_magnitude_comparator.sv
// Bench for serial_magnitude_comparator: a WIDTH=8 instance driven from a
// vector table plus hand-written multi-cycle sequences, and a WIDTH=4 instance
// swept over every operand pair. Expected results and done cycles are queued
// when a request is issued and checked when done pulses.
module tb_serial_magnitude_comparator;
    localparam logic [2:0] R_LT = 3'b100;
    localparam logic [2:0] R_GT = 3'b010;
    localparam logic [2:0] R_EQ = 3'b001;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_assert = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    // Cycle counter, read at negedge where it is stable.
    always @(posedge clk) cyc <= cyc + 1;

    serial_magnitude_comparator_if #(.WIDTH(8)) bus8 ();
    serial_magnitude_comparator_if #(.WIDTH(4)) bus4 ();

    serial_magnitude_comparator #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8));
    serial_magnitude_comparator #(.WIDTH(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4));

    typedef struct {
        logic [2:0] res;
        int         cyc;
        string      name;
    } exp_t;

    typedef struct {
        logic       sgn;
        logic [7:0] a;
        logic [7:0] b;
        logic       l;
        logic       e;
        logic       g;
        logic [2:0] res;
        int         d;
        string      name;
    } vec_t;

    exp_t q8[$];
    exp_t q4[$];
    exp_t e8;
    exp_t e4;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard: each done pulse pops the oldest expectation.
    always @(negedge clk) begin
        if (!rst && bus8.done) begin
            if (q8.size() == 0) begin
                check("done8_unexpected", 1, 0);
            end else begin
                e8 = q8.pop_front();
                check({e8.name, "_res"}, {bus8.LT, bus8.GT, bus8.EQ}, e8.res);
                check({e8.name, "_lat"}, cyc, e8.cyc);
            end
        end
        if (!rst && bus4.done) begin
            if (q4.size() == 0) begin
                check("done4_unexpected", 1, 0);
            end else begin
                e4 = q4.pop_front();
                check({e4.name, "_res"}, {bus4.LT, bus4.GT, bus4.EQ}, e4.res);
                check({e4.name, "_lat"}, cyc, e4.cyc);
            end
        end
    end

    // Called at a negedge; start is sampled at the following posedge.
    task automatic start8(input logic s, input logic [7:0] a, input logic [7:0] b,
                          input logic l, input logic e, input logic g,
                          input logic [2:0] res, input int d, input string name, input bit push);
        bus8.sgn = s; bus8.a = a; bus8.b = b;
        bus8.l = l; bus8.e = e; bus8.g = g;
        bus8.start = 1'b1;
        if (push) q8.push_back('{res: res, cyc: cyc + d + 1, name: name});
        @(negedge clk);
        bus8.start = 1'b0;
    endtask

    task automatic wait_done8(input int budget, output int busy_cnt, output bit ok);
        busy_cnt = 0;
        ok = 1'b0;
        for (int n = 0; n < budget; n++) begin
            if (bus8.done) begin
                ok = 1'b1;
                break;
            end
            if (bus8.busy) busy_cnt++;
            @(negedge clk);
        end
    endtask

    task automatic start4(input logic s, input logic [3:0] a, input logic [3:0] b,
                          input logic [2:0] res, input int d);
        bus4.sgn = s; bus4.a = a; bus4.b = b;
        bus4.l = 1'b0; bus4.e = 1'b0; bus4.g = 1'b0;
        bus4.start = 1'b1;
        q4.push_back('{res: res, cyc: cyc + d + 1, name: "sweep4"});
        @(negedge clk);
        bus4.start = 1'b0;
    endtask

    task automatic wait_done4(input int budget, output int busy_cnt, output bit ok);
        busy_cnt = 0;
        ok = 1'b0;
        for (int n = 0; n < budget; n++) begin
            if (bus4.done) begin
                ok = 1'b1;
                break;
            end
            if (bus4.busy) busy_cnt++;
            @(negedge clk);
        end
    endtask

    function automatic logic [2:0] ref4(input logic s, input logic [3:0] a, input logic [3:0] b);
        if (a == b) return R_EQ;
        if (s) return ($signed(a) < $signed(b)) ? R_LT : R_GT;
        return (a < b) ? R_LT : R_GT;
    endfunction

    function automatic int dist4(input logic [3:0] a, input logic [3:0] b);
        logic [3:0] x;
        x = a ^ b;
        for (int k = 3; k >= 0; k--) begin
            if (x[k]) return 4 - k;
        end
        return 4;
    endfunction

    vec_t tbl[12];

    initial begin
        int  bc;
        bit  ok;
        logic [2:0] r;
        int  d;

        tbl[0]  = '{1'b0, 8'h80, 8'h7F, 1'b0, 1'b0, 1'b0, R_GT, 1, "u_msb"};
        tbl[1]  = '{1'b1, 8'h80, 8'h01, 1'b0, 1'b0, 1'b0, R_LT, 1, "s_sign"};
        tbl[2]  = '{1'b0, 8'h80, 8'h01, 1'b0, 1'b0, 1'b0, R_GT, 1, "u_sign"};
        tbl[3]  = '{1'b0, 8'h5A, 8'h5A, 1'b0, 1'b0, 1'b1, R_GT, 8, "casc_g"};
        tbl[4]  = '{1'b0, 8'h5A, 8'h5A, 1'b0, 1'b1, 1'b0, R_EQ, 8, "casc_e"};
        tbl[5]  = '{1'b0, 8'h5A, 8'h5A, 1'b1, 1'b0, 1'b1, R_LT, 8, "casc_lg"};
        tbl[6]  = '{1'b0, 8'h5A, 8'h5A, 1'b0, 1'b0, 1'b0, R_EQ, 8, "casc_0"};
        tbl[7]  = '{1'b1, 8'hFF, 8'h01, 1'b0, 1'b0, 1'b0, R_LT, 1, "s_m1_1"};
        tbl[8]  = '{1'b1, 8'hFE, 8'hFF, 1'b0, 1'b0, 1'b0, R_LT, 8, "s_m2_m1"};
        tbl[9]  = '{1'b0, 8'h3C, 8'h34, 1'b0, 1'b0, 1'b0, R_GT, 5, "u_mid"};
        tbl[10] = '{1'b1, 8'h7F, 8'h80, 1'b0, 1'b0, 1'b0, R_GT, 1, "s_max_min"};
        tbl[11] = '{1'b0, 8'h00, 8'hFF, 1'b0, 1'b0, 1'b0, R_LT, 1, "u_zero_max"};

        bus8.start = 0; bus8.sgn = 0; bus8.a = 0; bus8.b = 0;
        bus8.l = 0; bus8.e = 0; bus8.g = 0;
        bus4.start = 0; bus4.sgn = 0; bus4.a = 0; bus4.b = 0;
        bus4.l = 0; bus4.e = 0; bus4.g = 0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        check("rst_out8", {bus8.busy, bus8.done, bus8.LT, bus8.GT, bus8.EQ}, 0);
        check("rst_out4", {bus4.busy, bus4.done, bus4.LT, bus4.GT, bus4.EQ}, 0);

        // Table-driven single operations.
        foreach (tbl[i]) begin
            start8(tbl[i].sgn, tbl[i].a, tbl[i].b, tbl[i].l, tbl[i].e, tbl[i].g,
                   tbl[i].res, tbl[i].d, tbl[i].name, 1);
            wait_done8(12, bc, ok);
            check({tbl[i].name, "_timeout"}, ok, 1);
            check({tbl[i].name, "_busycnt"}, bc, tbl[i].d);
            check({tbl[i].name, "_busy_at_done"}, bus8.busy, 0);
            @(negedge clk);
        end

        // Low-bit difference with a start pulse mid-scan that must be ignored.
        start8(0, 8'h10, 8'h11, 0, 0, 0, R_LT, 8, "lowbit", 1);
        @(negedge clk);
        @(negedge clk);
        bus8.a = 8'hFF; bus8.b = 8'h00; bus8.start = 1'b1;
        @(negedge clk);
        bus8.start = 1'b0;
        wait_done8(12, bc, ok);
        check("lowbit_timeout", ok, 1);
        repeat (3) @(negedge clk);
        check("lowbit_hold", {bus8.busy, bus8.LT, bus8.GT, bus8.EQ}, {1'b0, R_LT});

        // Back-to-back: second request issued in the done cycle of the first.
        start8(0, 8'h03, 8'h03, 0, 0, 0, R_EQ, 8, "b2b_eq", 1);
        wait_done8(12, bc, ok);
        check("b2b_eq_timeout", ok, 1);
        start8(0, 8'hFF, 8'h00, 0, 0, 0, R_GT, 1, "b2b_gt", 1);
        check("b2b_busy_rise", bus8.busy, 1);
        wait_done8(12, bc, ok);
        check("b2b_gt_timeout", ok, 1);
        check("b2b_gt_busycnt", bc, 1);
        @(negedge clk);

        // Reset during the second busy cycle abandons the scan silently.
        start8(0, 8'h5A, 8'h5A, 0, 0, 0, R_EQ, 8, "abort", 0);
        @(negedge clk);
        check("abort_busy", bus8.busy, 1);
        rst = 1'b1;
        @(negedge clk);
        check("abort_out", {bus8.busy, bus8.done, bus8.LT, bus8.GT, bus8.EQ}, 0);
        rst = 1'b0;
        repeat (12) @(negedge clk);
        check("abort_quiet", {bus8.busy, bus8.done}, 0);

        // Full WIDTH=4 sweep against a reference compare.
        for (int s = 0; s < 2; s++) begin
            for (int a = 0; a < 16; a++) begin
                for (int b = 0; b < 16; b++) begin
                    r = ref4(s[0], a[3:0], b[3:0]);
                    d = dist4(a[3:0], b[3:0]);
                    start4(s[0], a[3:0], b[3:0], r, d);
                    wait_done4(10, bc, ok);
                    check("sweep4_timeout", ok, 1);
                    check("sweep4_busycnt", bc, d);
                end
            end
        end

        repeat (3) @(negedge clk);
        check("q8_drained", q8.size(), 0);
        check("q4_drained", q4.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/serial_magnitude_comparator.md
# serial_magnitude_comparator

- Parametrised, sequential successor to the cascadable single-bit comparator.
- Latches two WIDTH-bit operands on a start request and scans them MSB-first, one bit per clock, stopping at the first differing bit.
- Supports unsigned and two's-complement signed compare.
- Honours cascade inputs from a less-significant stage, then reports a one-hot LT/GT/EQ result with a done pulse.
- Sits between operand registers and control logic wherever a small-area magnitude compare is acceptable in place of a wide combinational tree.

## Interface
- WIDTH, 8, operand width in bits; legal range 2..32.
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only when not busy.
- sgn  input  1  1 = two's-complement signed compare, 0 = unsigned; sampled with start.
- a  input  WIDTH  operand A; sampled with start.
- b  input  WIDTH  operand B; sampled with start.
- l, e, g  input  1 each  cascade less/equal/greater from a less-significant stage; sampled with start.
- busy  output  1  high while scanning.
- done  output  1  one-cycle pulse when LT/GT/EQ are updated.
- LT, GT, EQ  output  1 each  registered result, one-hot after the first completion.

## Operation
- States:
  - IDLE: waiting for start.
  - SCAN: comparing one bit per cycle.
  - DONE: done pulse cycle.
- Reset: state IDLE, busy=0, done=0, LT=GT=EQ=0, bit index=WIDTH-1, operand and cascade registers cleared.
- IDLE or DONE with start=1:
  - Latch a, b, sgn, l, e, g.
  - Set index=WIDTH-1 and enter SCAN.
- IDLE or DONE with start=0: go to (or stay in) IDLE.
- SCAN, bit i = index, bits differ:
  - Unsigned, or i≠WIDTH-1: a[i]=1 → GT, else LT.
  - Signed and i=WIDTH-1: a[i]=1 → LT, else GT (sign bit inverts the decision).
  - Load the result, enter DONE.
- SCAN, bits equal, i>0: index decrements by 1; stay in SCAN.
- SCAN, bits equal, i=0: result comes from the latched cascade inputs, priority l → LT, else g → GT, else EQ. Enter DONE. Non-one-hot or all-zero cascade inputs resolve by this priority, so l=e=g=0 gives EQ.
- start while in SCAN: ignored; latched operands are not disturbed.
- LT/GT/EQ hold their value from the previous completion until the next done pulse; exactly one of them is high after any completion.
- Index is a $clog2(WIDTH)-bit down-counter. It never wraps: the exit condition is tested at i=0.

## Timing
- Let start be sampled high at the clock edge ending cycle t, and let d be the number of bits examined.
  - d = WIDTH-k, where k is the index of the highest differing bit.
  - d = WIDTH when a==b.
- busy is high in cycles t+1 .. t+d.
- done is high in cycle t+d+1, for one cycle only; LT/GT/EQ take their new values in that same cycle.
- Latency from start to done: minimum 2 cycles (MSB differs), maximum WIDTH+1 cycles (equal operands).
- Back-to-back operation: start asserted during the done cycle is accepted, so busy rises in the next cycle. Sustained throughput is one result per d+1 cycles.
- rst=1 in any cycle overrides everything, including a simultaneous start. The next cycle shows reset values, and a scan in progress is abandoned with no done pulse.
- No combinational path from any input to any output.

## Test plan
- Unsigned MSB differs, WIDTH=8, sgn=0, a=8'h80, b=8'h7F, start at cycle t → busy high at t+1 only; done at t+2 with GT=1, LT=0, EQ=0.
- Signed sign-bit differs, sgn=1, a=8'h80 (−128), b=8'h01 → LT=1 at t+2. Same operands with sgn=0 → GT=1.
- Equal operands with cascade, a=b=8'h5A:
  - l=0, e=0, g=1 → busy t+1..t+8, done at t+9 with GT=1.
  - Repeat with l=0, e=1, g=0 → EQ=1.
  - Repeat with l=1, e=0, g=1 → LT=1 (priority).
- Low-bit difference plus ignored start, a=8'h10, b=8'h11:
  - Done at t+9 with LT=1.
  - A start pulse with new operands at t+3 is ignored; the result is unchanged.
- Back-to-back and reset:
  - Start a=3, b=3 at t. Start again during the done cycle with a=8'hFF, b=8'h00 → second done 2 cycles later with GT=1.
  - Then start a fresh op and assert rst at its second busy cycle → no done pulse; all outputs 0 in the next cycle.
- Sweep: WIDTH=4, all 256 (a,b) pairs × sgn∈{0,1}, l=e=g=0 → result matches the reference compare, and latency equals d+1 for every pair.
